// File: rtl/rr_pick.sv
// Round-robin selector: the first eligible channel strictly after `last`,
// searching upward and wrapping at n_ch.
module rr_pick #(
    parameter  int unsigned n_ch = 4,
    localparam int unsigned cw   = $clog2(n_ch)
) (
    input  logic [n_ch-1:0] eligible,
    input  logic [cw-1:0]   last,
    output logic            valid,
    output logic [cw-1:0]   idx
);

    function automatic logic [cw-1:0] offset_idx(input logic [cw-1:0] base, input int unsigned off);
        return cw'((32'(base) + off) % n_ch);
    endfunction

    // Walk the search order backwards so the nearest eligible channel is the last write.
    always_comb begin
        valid = 1'b0;
        idx   = last;
        for (int unsigned off = n_ch; off > 0; off--) begin
            if (eligible[offset_idx(last, off)]) begin
                valid = 1'b1;
                idx   = offset_idx(last, off);
            end
        end
    end

endmodule

// File: rtl/tx_arb_rr.sv
// Round-robin Tx arbiter: merges n_ch packet clients onto one transmitter port
// and flags packets whose strobed byte count differs from the requested length.
module tx_arb_rr #(
    parameter  int unsigned n_ch     = 4,
    parameter  int unsigned jumbo_dw = 14,
    localparam int unsigned cw       = $clog2(n_ch)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [n_ch-1:0]          en,
    input  logic [n_ch-1:0]          req,
    input  logic [n_ch*jumbo_dw-1:0] length,
    input  logic [n_ch*8-1:0]        data_tx,
    output logic [n_ch-1:0]          ack,
    output logic [n_ch-1:0]          strobe,
    output logic [n_ch-1:0]          warn,
    output logic                     out_req,
    output logic [jumbo_dw-1:0]      out_len,
    input  logic                     out_ack,
    input  logic                     out_strobe,
    input  logic                     out_warn,
    output logic [7:0]               out_data,
    output logic [cw-1:0]            grant,
    output logic [n_ch-1:0]          len_err,
    output logic [15:0]              pkt_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    logic [1:0]          state;
    logic [jumbo_dw-1:0] len_ch  [n_ch];
    logic [7:0]          data_ch [n_ch];
    logic                pick_valid;
    logic [cw-1:0]       pick_idx;
    logic [jumbo_dw-1:0] byte_cnt;
    logic [jumbo_dw-1:0] lat_len;
    logic                seen_strobe;

    for (genvar g = 0; g < n_ch; g++) begin : g_ch
        assign len_ch[g]  = length[g*jumbo_dw +: jumbo_dw];
        assign data_ch[g] = data_tx[g*8 +: 8];
    end

    rr_pick #(.n_ch(n_ch)) u_pick (
        .eligible (req & en),
        .last     (grant),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            grant       <= cw'(n_ch - 1);
            out_req     <= 1'b0;
            out_len     <= '0;
            byte_cnt    <= '0;
            lat_len     <= '0;
            seen_strobe <= 1'b0;
            len_err     <= '0;
            pkt_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick_idx;
                        out_req <= 1'b1;
                        out_len <= len_ch[pick_idx];
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An accept in the same cycle as a withdrawal still commits the packet.
                    if (out_ack) begin
                        out_req     <= 1'b0;
                        out_len     <= '0;
                        lat_len     <= len_ch[grant];
                        byte_cnt    <= '0;
                        seen_strobe <= 1'b0;
                        state       <= S_XFER;
                    end else if (!(req[grant] && en[grant])) begin
                        out_req <= 1'b0;
                        out_len <= '0;
                        state   <= S_IDLE;
                    end
                end
                S_XFER: begin
                    if (out_strobe) begin
                        seen_strobe <= 1'b1;
                        if (byte_cnt != '1) byte_cnt <= byte_cnt + jumbo_dw'(1);
                    end else if (seen_strobe) begin
                        pkt_cnt <= pkt_cnt + 16'd1;
                        if (byte_cnt != lat_len) len_err[grant] <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Zero-latency handshake forwarding, gated by state so reset silences it.
    always_comb begin
        ack      = '0;
        strobe   = '0;
        warn     = '0;
        out_data = '0;
        if (state == S_REQ) ack[grant] = out_ack;
        if (state == S_XFER) begin
            strobe[grant] = out_strobe;
            warn[grant]   = out_warn;
            out_data      = data_ch[grant];
        end
    end

endmodule

// File: tb/tb_tx_arb_rr.sv
// Randomized bench for tx_arb_rr against a transaction-level round-robin model.
module tb_tx_arb_rr;

    localparam int N  = 4;
    localparam int JW = 14;
    localparam int CW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    en, req, ack, strobe, warn, len_err;
    logic [N*JW-1:0] length;
    logic [N*8-1:0]  data_tx;
    logic            out_req, out_ack, out_strobe, out_warn;
    logic [JW-1:0]   out_len;
    logic [7:0]      out_data;
    logic [CW-1:0]   grant;
    logic [15:0]     pkt_cnt;

    int checks   = 0;
    int failures = 0;

    logic [CW-1:0] m_grant;
    logic [15:0]   m_pkt;
    logic [N-1:0]  m_err;

    tx_arb_rr #(.n_ch(N), .jumbo_dw(JW)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .length(length), .data_tx(data_tx),
        .ack(ack), .strobe(strobe), .warn(warn), .out_req(out_req), .out_len(out_len),
        .out_ack(out_ack), .out_strobe(out_strobe), .out_warn(out_warn), .out_data(out_data),
        .grant(grant), .len_err(len_err), .pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next channel after `last` in circular order that is in `elig`; MSB = found.
    function automatic logic [CW:0] pick(input logic [CW-1:0] last, input logic [N-1:0] elig);
        logic [CW-1:0] c = last;
        for (int k = 0; k < N; k++) begin
            c = c + CW'(1);
            if (elig[c]) return {1'b1, c};
        end
        return '0;
    endfunction

    function automatic logic [JW-1:0] len_of(input logic [CW-1:0] c);
        logic [N*JW-1:0] t = length >> (32'(c) * JW);
        return t[JW-1:0];
    endfunction

    function automatic logic [7:0] dat_of(input logic [CW-1:0] c);
        logic [N*8-1:0] t = data_tx >> (32'(c) * 8);
        return t[7:0];
    endfunction

    task automatic set_len_all(input logic [JW-1:0] v);
        for (int i = 0; i < N; i++) length = {v, length[N*JW-1:JW]};
    endtask

    task automatic rand_len();
        for (int i = 0; i < N; i++) length = {JW'($urandom_range(6, 2)), length[N*JW-1:JW]};
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) data_tx = {8'($urandom_range(255, 1)), data_tx[N*8-1:8]};
    endtask

    // mode 0: accept, 1: req withdrawn, 2: en withdrawn, 3: accept with coincident withdrawal.
    // The transmitter strobes (latched length + delta) bytes, at least one.
    task automatic do_pkt(input logic [N-1:0] rq, input logic [N-1:0] ev, input int mode, input int delta);
        logic [CW:0]   p;
        logic [CW-1:0] g;
        logic [N-1:0]  oh;
        logic [JW-1:0] l;
        int            nstb;
        req = rq; en = ev; out_ack = 1'b0; out_strobe = 1'b0; out_warn = 1'b0;
        p = pick(m_grant, rq & ev);
        g = p[CW-1:0];
        tick();
        if (!p[CW]) begin
            chk("no_eligible_req", 32'(out_req), 32'd0);
            req = '0;
            return;
        end
        oh = N'(1) << g;
        m_grant = g;
        chk("req_up", 32'(out_req), 32'd1);
        chk("grant", 32'(grant), 32'(g));
        chk("out_len", 32'(out_len), 32'(len_of(g)));
        chk("ack_quiet", 32'(ack), 32'd0);
        chk("req_data_zero", 32'(out_data), 32'd0);
        repeat ($urandom_range(1, 0)) begin
            tick();
            chk("req_hold", 32'(out_req), 32'd1);
        end
        if (mode == 1 || mode == 2) begin
            if (mode == 1) req = req & ~oh;
            else en = en & ~oh;
            #1;
            chk("abort_no_ack", 32'(ack), 32'd0);
            tick();
            req = '0;
            chk("abort_req_clr", 32'(out_req), 32'd0);
            chk("abort_grant", 32'(grant), 32'(g));
            chk("abort_pkt", 32'(pkt_cnt), 32'(m_pkt));
            chk("abort_err", 32'(len_err), 32'(m_err));
            return;
        end
        out_ack = 1'b1;
        if (mode == 3) req = req & ~oh;
        #1;
        chk("ack_pulse", 32'(ack), 32'(oh));
        l = len_of(g);
        tick();
        out_ack = 1'b0;
        req = '0;
        chk("req_clr", 32'(out_req), 32'd0);
        chk("ack_clr", 32'(ack), 32'd0);
        // Late length changes and channel disable must not disturb the transfer.
        rand_len();
        if ($urandom_range(1, 0) == 1) en = en & ~oh;
        repeat ($urandom_range(2, 0)) begin
            rand_data();
            #1;
            chk("pre_strobe", 32'(strobe), 32'd0);
            chk("pre_data", 32'(out_data), 32'(dat_of(g)));
            tick();
        end
        nstb = int'(l) + delta;
        if (nstb < 1) nstb = 1;
        for (int k = 0; k < nstb; k++) begin
            out_strobe = 1'b1;
            out_warn = 1'($urandom);
            rand_data();
            #1;
            chk("strobe", 32'(strobe), 32'(oh));
            chk("warn", 32'(warn), out_warn ? 32'(oh) : 32'd0);
            chk("data", 32'(out_data), 32'(dat_of(g)));
            tick();
        end
        out_strobe = 1'b0;
        out_warn = 1'b0;
        #1;
        chk("strobe_end", 32'(strobe), 32'd0);
        tick();
        m_pkt = m_pkt + 16'd1;
        if (nstb != int'(l)) m_err[g] = 1'b1;
        chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
        chk("len_err", 32'(len_err), 32'(m_err));
        chk("idle_data", 32'(out_data), 32'd0);
    endtask

    initial begin
        logic [CW:0] p;
        rst = 1'b1;
        req = '0; en = '0; out_ack = 1'b0; out_strobe = 1'b0; out_warn = 1'b0;
        length = '0;
        rand_data();
        m_grant = CW'(N - 1); m_pkt = '0; m_err = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'(N - 1));
        chk("rst_out_req", 32'(out_req), 32'd0);
        chk("rst_out_len", 32'(out_len), 32'd0);
        chk("rst_pkt", 32'(pkt_cnt), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        tick();

        // Fully loaded: strict rotation 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            set_len_all(JW'(3));
            do_pkt('1, '1, 0, 0);
        end
        chk("rotation_pkt5", 32'(pkt_cnt), 32'd5);
        chk("rotation_last", 32'(grant), 32'd0);

        // Channel 2 withdraws before accept.
        do_pkt(4'b0100, '1, 1, 0);
        chk("withdraw_grant", 32'(grant), 32'd2);
        chk("withdraw_pkt", 32'(pkt_cnt), 32'd5);

        // Masked channel 2 is skipped.
        for (int i = 0; i < 6; i++) begin
            set_len_all(JW'(3));
            do_pkt('1, 4'b1011, 0, 0);
            chk("mask_no_ch2", 32'(grant == 2'd2), 32'd0);
        end

        // Short packet sets a sticky error that a good packet does not clear.
        set_len_all(JW'(5));
        do_pkt(4'b0010, '1, 0, -1);
        chk("short_err", 32'(len_err[1]), 32'd1);
        set_len_all(JW'(5));
        do_pkt(4'b0010, '1, 0, 0);
        chk("err_sticky", 32'(len_err[1]), 32'd1);

        // Accept wins over a coincident withdrawal.
        set_len_all(JW'(3));
        do_pkt('1, '1, 3, 0);

        // Reset in the middle of a transfer.
        set_len_all(JW'(4));
        req = '1; en = '1;
        p = pick(m_grant, '1);
        tick();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0; req = '0; out_strobe = 1'b1; out_warn = 1'b1;
        tick();
        chk("pre_rst_strobe", 32'(strobe), 32'(N'(1) << p[CW-1:0]));
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", 32'(ack), 32'd0);
        chk("rst_mid_strobe", 32'(strobe), 32'd0);
        chk("rst_mid_warn", 32'(warn), 32'd0);
        chk("rst_mid_data", 32'(out_data), 32'd0);
        chk("rst_mid_req", 32'(out_req), 32'd0);
        chk("rst_mid_pkt", 32'(pkt_cnt), 32'd0);
        chk("rst_mid_err", 32'(len_err), 32'd0);
        out_strobe = 1'b0; out_warn = 1'b0;
        m_grant = CW'(N - 1); m_pkt = '0; m_err = '0;
        tick();
        rst = 1'b0;
        tick();
        set_len_all(JW'(3));
        do_pkt('1, '1, 0, 0);
        chk("post_rst_grant0", 32'(grant), 32'd0);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            int d;
            rand_len();
            d = int'($urandom_range(3, 0)) - 1;
            if (d == 2) d = 0;
            do_pkt(N'($urandom), N'($urandom) | N'($urandom), int'($urandom_range(3, 0)), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
